// File: rtl/sync_fifo_ctrl.sv
// Single-clock show-ahead FIFO: circular-buffer storage, occupancy count and watermark flags.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_EN is defined.
module sync_fifo_ctrl #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       err_clr_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic                       ovf_o,
    output logic                       udf_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [PW-1:0]    wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [CW-1:0]    count_r, count_nxt_s;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_acc_s, pop_acc_s;

    // Explicit wrap compare so non-power-of-2 depths index correctly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == LAST_C) begin
            return '0;
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Acceptance decisions, pointer and count next-state from pre-edge state.
    always_comb begin
        pop_acc_s    = pop_i & (count_r != '0);
        push_acc_s   = push_i & ((count_r != DEPTH_C) | pop_acc_s);
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (push_acc_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_acc_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (push_acc_s && !pop_acc_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (pop_acc_s && !push_acc_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Storage array; deliberately not reset, a full push+pop writes the slot being freed.
    always_ff @(posedge clk_i) begin
        if (push_acc_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    assign data_o         = (count_r != '0) ? mem_r[rd_ptr_r] : '0;
    assign count_o        = count_r;
    assign full_o         = (count_r == DEPTH_C);
    assign empty_o        = (count_r == '0);
    assign almost_full_o  = (count_r >= AF_C);
    assign almost_empty_o = (count_r <= AE_C);

`ifdef FIFO_ERR_EN
    logic ovf_r, udf_r, ovf_nxt_s, udf_nxt_s;

    // Sticky error flags; a new error on the clearing edge takes priority.
    always_comb begin
        ovf_nxt_s = ovf_r;
        udf_nxt_s = udf_r;
        if (push_i && !push_acc_s) begin
            ovf_nxt_s = 1'b1;
        end else if (err_clr_i) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
        if (pop_i && !pop_acc_s) begin
            udf_nxt_s = 1'b1;
        end else if (err_clr_i) begin
            udf_nxt_s = 1'b0;
        end else begin
            udf_nxt_s = udf_r;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_nxt_s;
            udf_r <= udf_nxt_s;
        end
    end

    assign ovf_o = ovf_r;
    assign udf_o = udf_r;
`else
    logic unused_err_clr_s;

    assign unused_err_clr_s = err_clr_i;
    assign ovf_o            = 1'b0;
    assign udf_o            = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomised and directed bench for sync_fifo_ctrl (WIDTH=8, DEPTH=4, AF=3, AE=1),
// compared against a queue-based reference model.
module tb_sync_fifo_ctrl;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic         clk;
    logic         rst_i;
    logic         push_i;
    logic         pop_i;
    logic [W-1:0] data_i;
    logic         err_clr_i;
    logic [W-1:0] data_o;
    logic [2:0]   count_o;
    logic         full_o, empty_o, almost_full_o, almost_empty_o, ovf_o, udf_o;

    int n_total = 0;
    int n_bad   = 0;

    logic [W-1:0] q[$];
    logic         m_ovf = 1'b0;
    logic         m_udf = 1'b0;

    sync_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk_i(clk), .rst_i(rst_i), .push_i(push_i), .pop_i(pop_i), .data_i(data_i),
        .err_clr_i(err_clr_i), .data_o(data_o), .count_o(count_o), .full_o(full_o),
        .empty_o(empty_o), .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
        .ovf_o(ovf_o), .udf_o(udf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check_val({tag, ".count"}, 32'(count_o), 32'(n));
        check_val({tag, ".empty"}, 32'(empty_o), 32'(n == 0));
        check_val({tag, ".full"},  32'(full_o),  32'(n == D));
        check_val({tag, ".afull"}, 32'(almost_full_o),  32'(n >= AF));
        check_val({tag, ".aempty"}, 32'(almost_empty_o), 32'(n <= AE));
        check_val({tag, ".data"},  32'(data_o), (n != 0) ? 32'(q[0]) : 32'h0);
        check_val({tag, ".ovf"},   32'(ovf_o), 32'(m_ovf));
        check_val({tag, ".udf"},   32'(udf_o), 32'(m_udf));
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1 time unit later.
    task automatic step(input logic push, input logic pop, input logic [W-1:0] d,
                        input logic clr, input string tag);
        bit pop_ok, push_ok;
        push_i    = push;
        pop_i     = pop;
        data_i    = d;
        err_clr_i = clr;
        pop_ok  = pop && (q.size() > 0);
        push_ok = push && ((q.size() < D) || pop_ok);
        @(posedge clk);
        if (pop_ok)  void'(q.pop_front());
        if (push_ok) q.push_back(d);
`ifdef FIFO_ERR_EN
        m_ovf = (push && !push_ok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_udf = (pop && !pop_ok)   ? 1'b1 : (clr ? 1'b0 : m_udf);
`endif
        #1;
        push_i = 1'b0; pop_i = 1'b0; err_clr_i = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        rst_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; data_i = 8'h00; err_clr_i = 1'b0;
        #2;
        check_all("in_reset");
        #10;
        rst_i = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0, "idle");

        foreach (vals[i]) step(1'b1, 1'b0, vals[i], 1'b0, "fill");
        check_val("fill_head", 32'(data_o), 32'h11);
        check_val("fill_full", 32'(full_o), 32'h1);

        step(1'b1, 1'b0, 8'h55, 1'b0, "push_full");
        step(1'b0, 1'b0, 8'h00, 1'b1, "err_clr");

        step(1'b1, 1'b1, 8'h66, 1'b0, "pushpop_full");
        check_val("pushpop_head", 32'(data_o), 32'h22);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "drain");
        check_val("drain_empty", 32'(empty_o), 32'h1);

        step(1'b1, 1'b1, 8'hA5, 1'b0, "pushpop_empty");
        check_val("pp_empty_data", 32'(data_o), 32'hA5);
        step(1'b0, 1'b1, 8'h00, 1'b0, "pop_last");
        step(1'b0, 1'b1, 8'h00, 1'b0, "pop_empty");
        step(1'b0, 1'b0, 8'h00, 1'b1, "err_clr2");

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, "pre_rst");
        #3;
        rst_i = 1'b0;
        #1;
        q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        check_val("async_rst_count", 32'(count_o), 32'h0);
        check_val("async_rst_empty", 32'(empty_o), 32'h1);
        @(posedge clk);
        #3;
        rst_i = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0, "post_rst");
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 8'(8'h70 + i), 1'b0, "wrap_push");
            step(1'b0, 1'b1, 8'h00, 1'b0, "wrap_pop");
        end

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 7) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
